// File: rtl/tdc_defs.sv
// Shared definitions for the TDC-source -> byte-FIFO write path.
// Also consumed by the fake TDC source.
package tdc_defs;

  localparam int          TDC_BYTE_W     = 8;
  localparam int          TDC_DATA_BYTES = 3;
  localparam logic [15:0] TDC_STALL_MAX  = 16'd1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } tdc_wr_state_e;

endpackage

// File: rtl/tdc_fifo_writer.sv
// Latches one TDC measurement per wr_en request and pushes it MSB-first into the byte FIFO.
// Optional macro TDC_WR_SEQ_EN prefixes every frame with an 8-bit sequence byte.
module tdc_fifo_writer
  import tdc_defs::*;
#(
  parameter int          DATA_BYTES = TDC_DATA_BYTES,
  parameter logic [15:0] STALL_MAX  = TDC_STALL_MAX
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATA_BYTES*TDC_BYTE_W-1:0] tdc_data,
  input  logic                             fifo_full,
  output logic [TDC_BYTE_W-1:0]            fifo_din,
  output logic                             fifo_wr,
  output logic                             writing_done,
  output logic                             busy,
  output logic [15:0]                      drop_cnt
);

`ifdef TDC_WR_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif
  localparam int DW          = DATA_BYTES * TDC_BYTE_W;
  localparam int FRAME_BYTES = DATA_BYTES + (SEQ_EN ? 1 : 0);
  localparam int IDX_W       = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  tdc_wr_state_e    state_q, state_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      stall_q, stall_d;
  logic [15:0]      drop_q, drop_d;
`ifdef TDC_WR_SEQ_EN
  logic [7:0]       seq_q, seq_d;
`endif

  assign fifo_wr      = (state_q == ST_WRITE) && !fifo_full;
  assign writing_done = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign drop_cnt     = drop_q;
`ifdef TDC_WR_SEQ_EN
  assign fifo_din     = (idx_q == '0) ? seq_q : shift_q[DW-1 -: TDC_BYTE_W];
`else
  assign fifo_din     = shift_q[DW-1 -: TDC_BYTE_W];
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    drop_d  = drop_q;
`ifdef TDC_WR_SEQ_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          shift_d = tdc_data;
          idx_d   = '0;
          stall_d = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!fifo_full) begin
          idx_d = idx_q + IDX_W'(1);
          // With the sequence byte enabled, byte 0 comes from seq_q and must not consume data.
          if (!SEQ_EN || idx_q != '0) shift_d = shift_q << TDC_BYTE_W;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
`ifdef TDC_WR_SEQ_EN
            seq_d   = seq_q + 8'd1;
`endif
          end
        end else if (idx_q == '0) begin
          // Only a frame that has not started may be dropped; started frames wait forever.
          if (stall_q == STALL_MAX) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = ST_DONE;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      ST_DONE:     state_d = wr_en ? ST_WAIT_LOW : ST_IDLE;
      ST_WAIT_LOW: if (!wr_en) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stall_q <= '0;
      drop_q  <= '0;
`ifdef TDC_WR_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      drop_q  <= drop_d;
`ifdef TDC_WR_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

endmodule
